wb_spi_ctrl: RTL and testbench

// Wishbone B3 responder holding an 8-bit SPI master (mode 0, MSB first) for SD card and flash access.

---
 rtl/wb_spi_ctrl_if.sv | 14 +
 rtl/wb_spi_ctrl.sv | 151 +++++++++++++++
 tb/tb_wb_spi_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_spi_ctrl_if.sv
// rtl/wb_spi_ctrl_if.sv - Wishbone B3 classic bus bundle for the SPI controller slot
interface wb_spi_ctrl_if;
  logic [3:0]  adr;
  logic [31:0] dat_wr;
  logic [31:0] dat_rd;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (output adr, dat_wr, sel, we, stb, cyc, input dat_rd, ack);
  modport slave  (input adr, dat_wr, sel, we, stb, cyc, output dat_rd, ack);
endinterface

// File: rtl/wb_spi_ctrl.sv
// rtl/wb_spi_ctrl.sv - Wishbone responder with an 8-bit mode-0 MSB-first SPI master
// Registers: DATA 0x0, CTRL 0x4 (BUSY/DONE/IE/OVR/DIV), CS 0x8, reserved 0xC.
module wb_spi_ctrl #(
  parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_spi_ctrl_if.slave     bus,
  output logic             irq_o,
  output logic             spi_sclk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i,
  output logic             spi_cs_no
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  logic [1:0]  state;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [7:0]  div;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx;
  logic        miso_q;
  logic        sclk;
  logic        mosi;
  logic        cs;
  logic        ie;
  logic        done;
  logic        ovr;
  logic        irq;

  logic        accept;
  logic        wr;
  logic        wr_data;
  logic        wr_ctrl0;
  logic        wr_ctrl1;
  logic        wr_cs;
  logic        busy;
  logic        half_tick;
  logic        done_nxt;
  logic        ie_nxt;
  logic [31:0] rdata;
  logic        unused_bits;

  assign accept    = bus.stb & bus.cyc & ~ack_q;
  assign wr        = accept & bus.we;
  assign wr_data   = wr && (bus.adr[3:2] == 2'd0) && bus.sel[0];
  assign wr_ctrl0  = wr && (bus.adr[3:2] == 2'd1) && bus.sel[0];
  assign wr_ctrl1  = wr && (bus.adr[3:2] == 2'd1) && bus.sel[1];
  assign wr_cs     = wr && (bus.adr[3:2] == 2'd2) && bus.sel[0];
  assign busy      = (state != IDLE);
  // >= rather than == so a DIV lowered mid-transfer still ends the current half-period
  assign half_tick = (state == SHIFT) && (div_cnt >= div);

  assign unused_bits = ^{bus.adr[1:0], bus.dat_wr[31:16], bus.sel[3:2]};

  always_comb begin
    done_nxt = done;
    if (wr_ctrl0 && bus.dat_wr[1]) done_nxt = 1'b0;
    if (state == DONE_ST)          done_nxt = 1'b1;
    ie_nxt = wr_ctrl0 ? bus.dat_wr[2] : ie;
  end

  always_comb begin
    rdata = '0;
    case (bus.adr[3:2])
      2'd0:    rdata = {24'h0, rx};
      2'd1:    rdata = {16'h0, div, 4'h0, ovr, ie, done, busy};
      2'd2:    rdata = {31'h0, cs};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      div     <= DEFAULT_DIV;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx      <= '0;
      miso_q  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
      ie      <= 1'b0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= accept ? rdata : 32'h0;
      done  <= done_nxt;
      ie    <= ie_nxt;
      irq   <= done_nxt & ie_nxt;
      if (wr_ctrl0 && bus.dat_wr[3]) ovr <= 1'b0;
      if (wr_data && busy)           ovr <= 1'b1;
      if (wr_ctrl1)                  div <= bus.dat_wr[15:8];
      if (wr_cs)                     cs  <= bus.dat_wr[0];

      case (state)
        IDLE: begin
          if (wr_data) begin
            state   <= SHIFT;
            shreg   <= bus.dat_wr[7:0];
            mosi    <= bus.dat_wr[7];
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (half_tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              miso_q <= spi_miso_i;
            end else begin
              shreg   <= {shreg[6:0], miso_q};
              mosi    <= shreg[6];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= DONE_ST;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE_ST: begin
          rx    <= shreg;
          sclk  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack    = ack_q;
  assign bus.dat_rd = dat_q;
  assign irq_o      = irq;
  assign spi_sclk_o = sclk;
  assign spi_mosi_o = mosi;
  assign spi_cs_no  = cs;

endmodule

// File: tb/tb_wb_spi_ctrl.sv
// tb/tb_wb_spi_ctrl.sv - randomized self-checking bench for wb_spi_ctrl against a bus-level model
module tb_wb_spi_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_spi_ctrl_if bus ();
  logic irq, sclk, mosi, cs_n, miso;
  logic inv = 1'b0;
  assign miso = mosi ^ inv;

  wb_spi_ctrl #(.DEFAULT_DIV(8'd3)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .bus        (bus),
    .irq_o      (irq),
    .spi_sclk_o (sclk),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso),
    .spi_cs_no  (cs_n)
  );

  int errors = 0;
  int checks = 0;

  // Model state: register file plus one transfer described by start cycle and divider
  int          mcyc = 0;
  bit          m_ack, m_active, m_inv, m_acc, m_fin, m_act_pre;
  logic [31:0] m_dat, m_rd;
  int          m_start, m_div_t;
  logic [7:0]  m_tx, m_div, m_rx;
  logic        m_ie, m_done, m_ovr, m_cs, m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] r);
    case (r)
      2'd0:    return {24'h0, m_rx};
      2'd1:    return {16'h0, m_div, 4'h0, m_ovr, m_ie, m_done, m_active};
      2'd2:    return {31'h0, m_cs};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ack = 0; m_active = 0; m_dat = 0; m_div = 8'd3; m_rx = 0;
    m_ie = 0; m_done = 0; m_ovr = 0; m_cs = 1; m_irq = 0;
  endtask

  task automatic model_step();
    mcyc++;
    m_acc = bus.stb && bus.cyc && !m_ack;
    m_act_pre = m_active;
    m_rd = model_read(bus.adr[3:2]);
    m_fin = 0;
    if (m_active && (mcyc - m_start) == 16 * (m_div_t + 1) + 1) begin
      m_fin = 1;
      m_active = 0;
      m_rx = m_tx ^ {8{m_inv}};
    end
    if (m_acc && bus.we) begin
      case (bus.adr[3:2])
        2'd0: if (bus.sel[0]) begin
          if (m_act_pre) m_ovr = 1;
          else begin
            m_active = 1; m_start = mcyc; m_tx = bus.dat_wr[7:0];
            m_div_t = int'(m_div); m_inv = inv;
          end
        end
        2'd1: begin
          if (bus.sel[0]) begin
            if (bus.dat_wr[1]) m_done = 0;
            m_ie = bus.dat_wr[2];
            if (bus.dat_wr[3]) m_ovr = 0;
          end
          if (bus.sel[1]) m_div = bus.dat_wr[15:8];
        end
        2'd2: if (bus.sel[0]) m_cs = bus.dat_wr[0];
        default: ;
      endcase
    end
    if (m_fin) m_done = 1;
    m_irq = m_done & m_ie;
    m_ack = m_acc;
    m_dat = m_rd;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      int e, n;
      logic exp_sclk;
      exp_sclk = 1'b0;
      n = 0;
      if (m_active) begin
        e = mcyc - m_start;
        n = e / (m_div_t + 1);
        exp_sclk = n[0];
      end
      check("ack", bus.ack, m_ack);
      if (m_ack) check("dat_o", bus.dat_rd, m_dat);
      check("irq", irq, m_irq);
      check("cs_n", cs_n, m_cs);
      check("sclk", sclk, exp_sclk);
      if (exp_sclk) check("mosi", mosi, m_tx[7 - (n / 2)]);
    end
  end

  task automatic wb(input bit we, input logic [3:0] adr, input logic [3:0] sel,
                    input logic [31:0] d, output logic [31:0] q);
    bit got;
    @(negedge clk);
    bus.stb = 1; bus.cyc = 1; bus.we = we; bus.adr = adr; bus.sel = sel; bus.dat_wr = d;
    q = '0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.ack) begin got = 1; q = bus.dat_rd; end
    end
    bus.stb = 0; bus.cyc = 0; bus.we = 0;
    check("wb_ack_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (m_active && k < bound) begin @(negedge clk); k++; end
    check("transfer_timeout", {31'h0, m_active}, 32'h0);
  endtask

  logic [31:0] q;
  logic [7:0]  rx_byte;
  int          pulses, rise_at;
  logic        prev;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stb = 0; bus.cyc = 0; bus.we = 0; bus.adr = 0; bus.sel = 0; bus.dat_wr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Reset state
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_irq",  irq,  1'b0);
    wb(0, 4'h0, 4'hF, 0, q); check("rst_data", q, 32'h0);
    wb(0, 4'h4, 4'hF, 0, q); check("rst_ctrl", q, 32'h0000_0300);
    wb(0, 4'h8, 4'hF, 0, q); check("rst_cs",   q, 32'h1);

    // DIV=0 loopback transfer of 0xA5
    wb(1, 4'h4, 4'hF, 32'h0000_0004, q);
    wb(1, 4'h0, 4'hF, 32'h0000_00A5, q);
    pulses = 0; rx_byte = 0; prev = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (sclk && !prev) begin pulses++; rx_byte = {rx_byte[6:0], mosi}; end
      prev = sclk;
      if (i == 16) check("irq_before_done", irq, 1'b0);
      if (i == 17) check("irq_at_17", irq, 1'b1);
    end
    check("sclk_pulses", pulses, 8);
    check("mosi_bits", rx_byte, 8'hA5);
    wb(0, 4'h0, 4'hF, 0, q); check("rx_a5", q, 32'hA5);
    wb(0, 4'h4, 4'hF, 0, q); check("ctrl_done", q, 32'h0000_0006);

    // Overrun while busy, then write-1-clear
    wb(1, 4'h0, 4'h1, 32'h0000_00A5, q);
    wb(1, 4'h0, 4'h1, 32'h0000_003C, q);
    wait_idle(100);
    wb(0, 4'h0, 4'hF, 0, q); check("rx_after_ovr", q, 32'hA5);
    wb(0, 4'h4, 4'hF, 0, q); check("ctrl_ovr", q, 32'h0000_000E);
    wb(1, 4'h4, 4'hF, 32'h0000_000A, q);
    wb(0, 4'h4, 4'hF, 0, q); check("ctrl_cleared", q, 32'h0);
    check("irq_cleared", irq, 1'b0);

    // Byte-lane enables on CTRL, then a DIV=0xFF transfer
    wb(1, 4'h4, 4'h1, 32'h0000_FF00, q);
    wb(0, 4'h4, 4'hF, 0, q); check("div_lane0_only", q, 32'h0);
    wb(1, 4'h4, 4'h2, 32'h0000_FF00, q);
    wb(0, 4'h4, 4'hF, 0, q); check("div_lane1", q, 32'h0000_FF00);
    wb(1, 4'h0, 4'h1, 32'h0000_0081, q);
    rise_at = 0;
    for (int k = 1; k <= 300 && rise_at == 0; k++) begin
      @(negedge clk);
      if (sclk) rise_at = k;
    end
    check("half_period_256", rise_at, 256);
    wait_idle(4300);

    // Reset in the middle of a transfer
    wb(1, 4'h4, 4'hF, 32'h0000_0100, q);
    wb(1, 4'h8, 4'h1, 32'h0, q);
    wb(1, 4'h0, 4'h1, 32'h0000_005A, q);
    repeat (13) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_ack",  bus.ack, 1'b0);
    @(negedge clk);
    rst_n = 1;
    wb(0, 4'h4, 4'hF, 0, q); check("post_rst_ctrl", q, 32'h0000_0300);
    wb(1, 4'h0, 4'h1, 32'h0000_00C3, q);
    wait_idle(100);
    wb(0, 4'h0, 4'hF, 0, q); check("post_rst_rx", q, 32'hC3);

    // stb held several cycles: single-cycle ACK pulse
    @(negedge clk);
    bus.stb = 1; bus.cyc = 1; bus.we = 0; bus.adr = 4'hC; bus.sel = 4'hF;
    @(negedge clk); check("held_ack_c2", bus.ack, 1'b1);
    @(negedge clk); check("held_ack_c3", bus.ack, 1'b0);
    repeat (2) @(negedge clk);
    bus.stb = 0; bus.cyc = 0;
    // stb withdrawn before any edge samples it
    @(negedge clk);
    bus.stb = 1; bus.cyc = 1; bus.we = 1; bus.adr = 4'h0; bus.sel = 4'h1; bus.dat_wr = 32'h99;
    #2 bus.stb = 0; bus.cyc = 0; bus.we = 0;
    repeat (3) @(negedge clk);
    check("abort_no_busy", {31'h0, m_active}, 32'h0);
    wb(0, 4'h4, 4'hF, 0, q); check("abort_ctrl", q, 32'h0000_0302);

    // Randomized transfers checked by the model
    for (int it = 0; it < 12; it++) begin
      logic [7:0] d;
      logic [3:0] s;
      d = 8'($urandom_range(0, 2));
      inv = 1'($urandom);
      s = ($urandom % 2) ? 4'hF : 4'h3;
      wb(1, 4'h4, s, {16'h0, d, 4'h0, 1'b1, 1'($urandom), 1'($urandom), 1'b0}, q);
      wb(1, 4'h8, 4'h1, {31'h0, 1'($urandom)}, q);
      s = ($urandom % 4 == 0) ? 4'hE : 4'h1;
      wb(1, 4'h0, s, $urandom, q);
      if ($urandom % 2) wb(1, 4'h0, 4'h1, $urandom, q);
      if ($urandom % 2) wb(1, 4'hC, 4'hF, $urandom, q);
      wait_idle(200);
      wb(0, 4'h0, 4'hF, 0, q);
      wb(0, 4'h4, 4'hF, 0, q);
      wb(0, 4'hC, 4'hF, 0, q);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
